// File: rtl/id_stage.sv
// Instruction-decode stage: register file, decoder, operand bypass,
// load-use interlock and the ID/EX pipeline register with handshake.
module id_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  input  logic                     ex_wen,
  input  logic [$clog2(NREG)-1:0]  ex_waddr,
  input  logic [XLEN-1:0]          ex_wdata,
  input  logic                     ex_is_load,
  input  logic                     mem_wen,
  input  logic [$clog2(NREG)-1:0]  mem_waddr,
  input  logic [XLEN-1:0]          mem_wdata,
  input  logic                     wb_wen,
  input  logic [$clog2(NREG)-1:0]  wb_waddr,
  input  logic [XLEN-1:0]          wb_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_op1,
  output logic [XLEN-1:0]          out_op2,
  output logic [XLEN-1:0]          out_imm,
  output logic [$clog2(NREG)-1:0]  out_waddr,
  output logic                     out_wen,
  output logic                     out_is_load,
  output logic                     out_is_store,
  output logic                     out_is_branch,
  output logic                     out_illegal,
  output logic [31:0]              stall_cnt
);

  localparam int unsigned AW  = $clog2(NREG);
  localparam bit          ZR  = (ZERO_REG != 0);
  localparam bit          BYP = (BYPASS != 0);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   waddr;
    logic            wen;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            illegal;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREG];
  idex_t           dec_c, idex_d, idex_q;
  logic            valid_d, valid_q;
  logic [31:0]     stall_d, stall_q;
  logic            use_rs, use_rt, wr, hazard, adv;
  logic [5:0]      op;
  logic [AW-1:0]   rs_a, rt_a, rd_a;
  logic [XLEN-1:0] sext16;

  // Operand source selection: zero, EX, MEM, WB write-through, then array
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a,
                                          input logic [XLEN-1:0] rf_v);
    logic [XLEN-1:0] r;
    if (ZR && a == '0)                                     r = '0;
    else if (BYP && ex_wen && !ex_is_load && ex_waddr == a) r = ex_wdata;
    else if (BYP && mem_wen && mem_waddr == a)              r = mem_wdata;
    else if (wb_wen && wb_waddr == a)                       r = wb_wdata;
    else                                                    r = rf_v;
    return r;
  endfunction

  // Instruction decode and operand read
  always_comb begin
    op      = in_inst[31:26];
    rs_a    = AW'(in_inst[25:21]);
    rt_a    = AW'(in_inst[20:16]);
    rd_a    = AW'(in_inst[15:11]);
    sext16  = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
    dec_c   = '0;
    dec_c.pc    = in_pc;
    dec_c.waddr = rt_a;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    wr      = 1'b0;
    case (op)
      6'h00: begin
        use_rs = 1'b1; use_rt = 1'b1; wr = 1'b1;
        dec_c.waddr = rd_a;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        use_rs = 1'b1; wr = 1'b1; dec_c.imm = sext16;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        use_rs = 1'b1; wr = 1'b1; dec_c.imm = XLEN'(in_inst[15:0]);
      end
      6'h0F: begin
        wr = 1'b1; dec_c.imm = XLEN'({in_inst[15:0], 16'h0000});
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin
        use_rs = 1'b1; wr = 1'b1; dec_c.is_load = 1'b1; dec_c.imm = sext16;
      end
      6'h28, 6'h29, 6'h2B: begin
        use_rs = 1'b1; use_rt = 1'b1; dec_c.is_store = 1'b1; dec_c.imm = sext16;
      end
      6'h04, 6'h05: begin
        use_rs = 1'b1; use_rt = 1'b1; dec_c.is_branch = 1'b1;
        dec_c.imm = {sext16[XLEN-3:0], 2'b00};
      end
      6'h02: begin
        dec_c.is_branch = 1'b1;
        dec_c.imm = XLEN'({in_pc[31:28], in_inst[25:0], 2'b00});
      end
      6'h03: begin
        dec_c.is_branch = 1'b1; wr = 1'b1;
        dec_c.waddr = AW'(5'd31);
        dec_c.imm = XLEN'({in_pc[31:28], in_inst[25:0], 2'b00});
      end
      default: dec_c.illegal = 1'b1;
    endcase
    dec_c.wen = wr && !(ZR && dec_c.waddr == '0);
    dec_c.op1 = fwd(rs_a, rf_q[rs_a]);
    dec_c.op2 = fwd(rt_a, rf_q[rt_a]);
  end

  // Interlock: load-use always; any EX/MEM dependency when not bypassing
  always_comb begin
    hazard = 1'b0;
    if (use_rs && rs_a != '0) begin
      if (ex_wen && ex_is_load && ex_waddr == rs_a) hazard = 1'b1;
      if (!BYP && ((ex_wen && ex_waddr == rs_a) || (mem_wen && mem_waddr == rs_a)))
        hazard = 1'b1;
    end
    if (use_rt && rt_a != '0) begin
      if (ex_wen && ex_is_load && ex_waddr == rt_a) hazard = 1'b1;
      if (!BYP && ((ex_wen && ex_waddr == rt_a) || (mem_wen && mem_waddr == rt_a)))
        hazard = 1'b1;
    end
  end

  assign adv      = !valid_q || out_ready;
  assign in_ready = adv && !hazard && !flush;

  // ID/EX next state: flush beats hazard beats normal advance; hold otherwise
  always_comb begin
    idex_d  = idex_q;
    valid_d = valid_q;
    stall_d = stall_q;
    if (in_valid && hazard && !flush) stall_d = stall_q + 32'd1;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      if (hazard) begin
        valid_d = 1'b0;
      end else begin
        idex_d  = dec_c;
        valid_d = in_valid;
      end
    end
  end

  // ID/EX register and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      idex_q  <= idex_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  // Register file write port; register 0 stays zero when hardwired
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_wen && !(ZR && wb_waddr == '0)) begin
      rf_q[wb_waddr] <= wb_wdata;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = idex_q.pc;
  assign out_op1       = idex_q.op1;
  assign out_op2       = idex_q.op2;
  assign out_imm       = idex_q.imm;
  assign out_waddr     = idex_q.waddr;
  assign out_wen       = idex_q.wen;
  assign out_is_load   = idex_q.is_load;
  assign out_is_store  = idex_q.is_store;
  assign out_is_branch = idex_q.is_branch;
  assign out_illegal   = idex_q.illegal;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode table plus hazard/handshake sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        ex_wen, ex_is_load, mem_wen, wb_wen;
  logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
  logic [31:0] ex_wdata, mem_wdata, wb_wdata;

  logic        in_ready, out_valid, out_wen, out_is_load, out_is_store, out_is_branch, out_illegal;
  logic [31:0] out_pc, out_op1, out_op2, out_imm, stall_cnt;
  logic [4:0]  out_waddr;

  logic        nb_in_ready, nb_out_valid, nb_out_wen, nb_out_is_load, nb_out_is_store;
  logic        nb_out_is_branch, nb_out_illegal;
  logic [31:0] nb_out_pc, nb_out_op1, nb_out_op2, nb_out_imm, nb_stall_cnt;
  logic [4:0]  nb_out_waddr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NREG(32), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .ex_is_load(ex_is_load), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_waddr(out_waddr), .out_wen(out_wen),
    .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_branch(out_is_branch), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  id_stage #(.XLEN(32), .NREG(32), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .ex_is_load(ex_is_load), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .out_valid(nb_out_valid),
    .out_ready(out_ready), .out_pc(nb_out_pc), .out_op1(nb_out_op1), .out_op2(nb_out_op2),
    .out_imm(nb_out_imm), .out_waddr(nb_out_waddr), .out_wen(nb_out_wen),
    .out_is_load(nb_out_is_load), .out_is_store(nb_out_is_store),
    .out_is_branch(nb_out_is_branch), .out_illegal(nb_out_illegal),
    .stall_cnt(nb_stall_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic        wen;
    logic        ld;
    logic        st;
    logic        br;
    logic        ill;
    logic        chk_op2;
    logic        chk_imm;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 1;
    in_inst = 32'h0; in_pc = 32'h0;
    ex_wen = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
    mem_wen = 0; mem_waddr = 0; mem_wdata = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  initial begin
    //          inst          pc            op1           op2           imm          wa  wen ld st br il co ci
    vecs[0] = '{32'h20A6FFFF, 32'h00000100, 32'h00001234, 32'h0,        32'hFFFFFFFF, 6, 1, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{32'h3C01ABCD, 32'h00000104, 32'h0,        32'h0,        32'hABCD0000, 1, 1, 0, 0, 0, 0, 0, 1};
    vecs[2] = '{32'hFC000000, 32'h00000108, 32'h0,        32'h0,        32'h00000000, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[3] = '{32'h0C000100, 32'h00400000, 32'h0,        32'h0,        32'h00000400, 31, 1, 0, 0, 1, 0, 0, 1};
    vecs[4] = '{32'h20A00005, 32'h00000110, 32'h00001234, 32'h0,        32'h00000005, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[5] = '{32'h8CA20008, 32'h00000114, 32'h00001234, 32'h0,        32'h00000008, 2, 1, 1, 0, 0, 0, 0, 1};
    vecs[6] = '{32'hACA5FFFC, 32'h00000118, 32'h00001234, 32'h00001234, 32'hFFFFFFFC, 0, 0, 0, 1, 0, 0, 1, 1};
    vecs[7] = '{32'h10A0FFFF, 32'h0000011C, 32'h00001234, 32'h0,        32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 1, 1};
    vecs[8] = '{32'h34A38000, 32'h00000120, 32'h00001234, 32'h0,        32'h00008000, 3, 1, 0, 0, 0, 0, 0, 1};
    vecs[9] = '{32'h00A53820, 32'h00000124, 32'h00001234, 32'h00001234, 32'h0,       7, 1, 0, 0, 0, 0, 1, 0};

    idle_inputs();
    rst = 1;
    step(); step();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset stall_cnt", stall_cnt, 32'd0);
    chk("reset out_op1", out_op1, 32'd0);
    chk("reset out_wen", 32'(out_wen), 32'd0);
    rst = 0;

    // write r5 through the WB port
    wb_wen = 1; wb_waddr = 5; wb_wdata = 32'h1234;
    step();
    wb_wen = 0;

    // decode table
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
      step();
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d pc", i), out_pc, vecs[i].pc);
      chk($sformatf("v%0d op1", i), out_op1, vecs[i].op1);
      if (vecs[i].chk_op2) chk($sformatf("v%0d op2", i), out_op2, vecs[i].op2);
      if (vecs[i].chk_imm) chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
      if (vecs[i].wen) chk($sformatf("v%0d waddr", i), 32'(out_waddr), 32'(vecs[i].waddr));
      chk($sformatf("v%0d wen", i), 32'(out_wen), 32'(vecs[i].wen));
      chk($sformatf("v%0d ld", i), 32'(out_is_load), 32'(vecs[i].ld));
      chk($sformatf("v%0d st", i), 32'(out_is_store), 32'(vecs[i].st));
      chk($sformatf("v%0d br", i), 32'(out_is_branch), 32'(vecs[i].br));
      chk($sformatf("v%0d ill", i), 32'(out_illegal), 32'(vecs[i].ill));
    end
    in_valid = 0;
    step();
    chk("idle out_valid", 32'(out_valid), 32'd0);

    // EX beats MEM; non-bypass instance stalls instead
    in_valid = 1; in_inst = 32'h20A6FFFF;
    ex_wen = 1; ex_waddr = 5; ex_wdata = 32'hAA; ex_is_load = 0;
    mem_wen = 1; mem_waddr = 5; mem_wdata = 32'hBB;
    #1;
    chk("byp in_ready", 32'(in_ready), 32'd1);
    chk("nb in_ready", 32'(nb_in_ready), 32'd0);
    step();
    chk("ex fwd op1", out_op1, 32'hAA);
    chk("ex fwd valid", 32'(out_valid), 32'd1);
    chk("nb bubble", 32'(nb_out_valid), 32'd0);
    chk("nb stall_cnt", nb_stall_cnt, 32'd1);
    ex_wen = 0;
    step();
    chk("mem fwd op1", out_op1, 32'hBB);
    chk("nb stall_cnt 2", nb_stall_cnt, 32'd2);
    mem_wen = 0;
    step();
    chk("nb issue valid", 32'(nb_out_valid), 32'd1);
    chk("nb issue op1", nb_out_op1, 32'h1234);
    chk("byp stall_cnt 0", stall_cnt, 32'd0);

    // load-use interlock on add r7,r5,r0
    in_inst = 32'h00A03820;
    ex_wen = 1; ex_is_load = 1; ex_waddr = 5; ex_wdata = 32'hDEAD;
    #1;
    chk("lu in_ready", 32'(in_ready), 32'd0);
    step();
    chk("lu bubble", 32'(out_valid), 32'd0);
    chk("lu stall_cnt", stall_cnt, 32'd1);
    ex_wen = 0; ex_is_load = 0;
    wb_wen = 1; wb_waddr = 5; wb_wdata = 32'h5555;
    #1;
    chk("lu release ready", 32'(in_ready), 32'd1);
    step();
    chk("lu wb fwd op1", out_op1, 32'h5555);
    chk("lu issue valid", 32'(out_valid), 32'd1);
    chk("lu issue waddr", 32'(out_waddr), 32'd7);
    wb_wen = 0;

    // load to r0 or to an unread rt does not interlock
    ex_wen = 1; ex_is_load = 1; ex_waddr = 0;
    in_inst = 32'h20060001;
    #1;
    chk("lu r0 no hazard", 32'(in_ready), 32'd1);
    ex_waddr = 6; in_inst = 32'h20A60001;
    #1;
    chk("lu rt unused no hazard", 32'(in_ready), 32'd1);
    ex_wen = 0; ex_is_load = 0;

    // backpressure: hold ori r3,r5,0x8000 for 3 cycles
    in_inst = 32'h34A38000;
    step();
    chk("bp load imm", out_imm, 32'h00008000);
    out_ready = 0; in_inst = 32'h3C01ABCD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("bp%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d imm", i), out_imm, 32'h00008000);
      chk($sformatf("bp%0d op1", i), out_op1, 32'h5555);
      chk($sformatf("bp%0d waddr", i), 32'(out_waddr), 32'd3);
    end
    out_ready = 1;
    #1;
    chk("bp release ready", 32'(in_ready), 32'd1);
    step();
    chk("bp next imm", out_imm, 32'hABCD0000);
    chk("bp next waddr", 32'(out_waddr), 32'd1);

    // flush kills ID/EX and rejects input
    flush = 1; in_inst = 32'h20A6FFFF;
    #1;
    chk("fl in_ready", 32'(in_ready), 32'd0);
    step();
    chk("fl valid", 32'(out_valid), 32'd0);
    chk("fl stall_cnt", stall_cnt, 32'd1);
    // flush beats a load-use hazard: no stall counted
    ex_wen = 1; ex_is_load = 1; ex_waddr = 5;
    step();
    chk("fl hz stall_cnt", stall_cnt, 32'd1);
    chk("fl hz valid", 32'(out_valid), 32'd0);
    flush = 0;
    step();
    chk("hz stall_cnt", stall_cnt, 32'd2);

    // reset mid-stall clears counter, outputs and register file
    rst = 1;
    step();
    rst = 0;
    chk("rst stall_cnt", stall_cnt, 32'd0);
    chk("rst valid", 32'(out_valid), 32'd0);
    ex_wen = 0; ex_is_load = 0;
    in_inst = 32'h20A6FFFF;
    step();
    chk("rst rf cleared op1", out_op1, 32'd0);
    chk("rst reissue valid", 32'(out_valid), 32'd1);

    in_valid = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Parametrised instruction-decode pipeline stage for the MIPS-subset pipeline CPU. Contains:
- the register file,
- the opcode/function decoder,
- operand forwarding from EX/MEM/WB,
- load-use interlock,
- the ID/EX pipeline register with valid/ready handshake and flush.

It sits between the IF/ID register and the EX stage. Compared with the previous combinational decode, it adds registered outputs, hazard handling and width/depth parameters.

Parameters:
- XLEN, 32, datapath width (must be ≥32); instruction width fixed at 32.
- NREG, 32, register count (power of 2); AW = log2(NREG).
- BYPASS, 1, 1 = forward from EX/MEM; 0 = stall on any EX/MEM dependency.
- ZERO_REG, 1, 1 = register 0 reads as zero and is never written.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  kill ID/EX contents and the current input (branch/jump redirect)
- ex_wen / ex_waddr / ex_wdata / ex_is_load  in  1/AW/XLEN/1  EX-stage result bypass
- mem_wen / mem_waddr / mem_wdata  in  1/AW/XLEN  MEM-stage bypass
- wb_wen / wb_waddr / wb_wdata  in  1/AW/XLEN  register-file write port
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  EX consumes ID/EX this cycle
- out_pc, out_op1, out_op2, out_imm  out  XLEN each  registered PC, operands, extended immediate
- out_waddr  out  AW  destination register
- out_wen, out_is_load, out_is_store, out_is_branch, out_illegal  out  1 each  control flags
- stall_cnt  out  32  cycles spent in hazard stall

Behaviour:
Decode (combinational on in_inst):
- op 0x00 R-type: reads rs, rt; writes rd.
- op 0x08–0x0B: reads rs; writes rt; imm sign-extended.
- op 0x0C–0x0E: reads rs; writes rt; imm zero-extended.
- op 0x0F lui: no reads; writes rt; imm = inst[15:0]<<16.
- op 0x20–0x25 loads: reads rs; writes rt; is_load; imm sign-extended.
- op 0x28/0x29/0x2B stores: reads rs, rt; no write; is_store; imm sign-extended.
- op 0x04/0x05: reads rs, rt; no write; is_branch; imm = sext(imm)<<2.
- op 0x02 j: no reads; no write; is_branch; imm = {pc[31:28], index, 2'b00}, zero-extended.
- op 0x03 jal: as j, plus writes register 31 with out_wen=1.
- Any other op: illegal=1, wen=0; the instruction still propagates.
- wen is forced to 0 when the destination is 0 and ZERO_REG=1.

Operand source priority, per read port:
1. Zero, when addr==0 and ZERO_REG=1.
2. EX, when ex_wen and address match, not ex_is_load, and BYPASS=1.
3. MEM, when mem_wen and match, and BYPASS=1.
4. WB write-through, when wb_wen and match.
5. Register-file array.

Register file:
- NREG×XLEN, written on the rising edge when wb_wen is set, except for address 0 when ZERO_REG=1.
- Reads are combinational.

Hazard (applies only to ports the instruction actually reads):
- Load-use: ex_wen && ex_is_load && ex_waddr matches a used nonzero source.
- When BYPASS=0, any ex_wen or mem_wen match with a used nonzero source is also a hazard.

Handshake:
- adv = !out_valid || out_ready.
- in_ready = adv && !hazard && !flush.
- When adv: the ID/EX register loads the decoded instruction with out_valid = in_valid && in_ready, or a bubble (out_valid=0) on hazard.
- When !adv: ID/EX holds all fields; hazard is irrelevant.
- stall_cnt increments (wrapping) on each cycle with in_valid && hazard && !flush.

Flush:
- The next state has out_valid=0, and the input is not accepted.
- Flush has priority over hazard and out_ready; rst has priority over flush.

Reset:
- All out_* = 0, out_valid = 0, stall_cnt = 0, every register-file entry = 0.
- Reset asserted mid-stall or mid-flush discards everything.

Latency: 1 cycle from an accepted input to out_valid.

Test Plan:
1. Reset, then wb writes r5=0x1234. Then `addi r6,r5,-1` (0x20A6FFFF) → next cycle out_op1=0x1234, out_imm=0xFFFFFFFF, out_waddr=6, out_wen=1.
2. ex_wen=1, ex_waddr=5, ex_wdata=0xAA, ex_is_load=0, with mem also writing r5=0xBB → out_op1=0xAA (EX priority). With BYPASS=0, the same stimulus → in_ready=0, a bubble is issued, and stall_cnt=1.
3. Load-use: ex_is_load=1, ex_waddr=5, then `add r7,r5,r0` → one bubble, in_ready=0, stall_cnt=1. Next cycle (load gone) the instruction issues with the WB-forwarded value.
4. out_ready=0 for 3 cycles with out_valid=1 → out_* stable, in_ready=0. Release → the held instruction is consumed and the new one loads the following cycle.
5. flush asserted while in_valid=1 and out_valid=1 → next cycle out_valid=0, input not accepted, stall_cnt unchanged.
6. `lui` 0x3C01ABCD → out_imm=0xABCD0000. Opcode 0x3F → out_illegal=1, out_wen=0. `jal` at pc=0x00400000 with index 0x100 → out_waddr=31, out_imm=0x00000400. `addi` writing r0 → out_wen=0.
